// File: rtl/encoder83_pkg.sv
// Shared widths, FSM state type and the code-to-mask helper for the 8-to-3 serializer.
package encoder83_pkg;

  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [VEC_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [VEC_W-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prienc83.sv
// Combinational 8-to-3 priority encoder; also flags any-set and exactly-one-set.
module prienc83
  import encoder83_pkg::*;
#(
  parameter bit PRIORITY_LSB = 1'b1
) (
  input  logic [VEC_W-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any,
  output logic              single
);

  // The winning bit is the one written last in the scan.
  always_comb begin
    code = '0;
    if (PRIORITY_LSB) begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) code = CODE_W'(i);
      end
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - VEC_W'(1))) == '0);

endmodule

// File: rtl/encoder83_serializer.sv
// Accepts an 8-bit request vector and emits the binary index of each set bit, one per handshake.
module encoder83_serializer
  import encoder83_pkg::*;
#(
  parameter bit PRIORITY_LSB = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              zero_seen
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   pending_q, pending_d;
  logic               zero_seen_q, zero_seen_d;

  logic [CODE_W-1:0]  enc_code;
  logic               enc_any;
  logic               enc_single;

  prienc83 #(
    .PRIORITY_LSB(PRIORITY_LSB)
  ) u_prienc (
    .vec    (pending_q),
    .code   (enc_code),
    .any    (enc_any),
    .single (enc_single)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_seen_d = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_code    = '0;
    out_last    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_code  = enc_code;
        out_last  = enc_single;
        if (!enc_any) begin
          state_d = IDLE;
        end else if (out_ready) begin
          pending_d = pending_q & ~onehot_of(enc_code);
          if (enc_single) begin
            state_d  = IDLE;
            in_ready = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A vector taken on the final handshake reloads pending with no bubble.
    if (in_ready && in_valid) begin
      if (in_vec != '0) begin
        pending_d = in_vec;
        state_d   = EMIT;
      end else begin
        zero_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_seen_q <= zero_seen_d;
    end
  end

  assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_encoder83_serializer.sv
// Directed bench for both priority orders; a queue of expected codes is checked per handshake.
module tb_encoder83_serializer;

  typedef struct packed {
    logic [2:0] code;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid_lsb, in_valid_msb;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       in_ready_lsb, out_valid_lsb, out_last_lsb, zero_seen_lsb;
  logic [2:0] out_code_lsb;
  logic       in_ready_msb, out_valid_msb, out_last_msb, zero_seen_msb;
  logic [2:0] out_code_msb;

  int   checks   = 0;
  int   failures = 0;
  bit   sel_msb  = 1'b0;
  bit   zs_exp   = 1'b0;
  exp_t q[$];

  encoder83_serializer #(.PRIORITY_LSB(1'b1)) dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_lsb),
    .in_ready  (in_ready_lsb),
    .in_vec    (in_vec),
    .out_valid (out_valid_lsb),
    .out_ready (out_ready),
    .out_code  (out_code_lsb),
    .out_last  (out_last_lsb),
    .zero_seen (zero_seen_lsb)
  );

  encoder83_serializer #(.PRIORITY_LSB(1'b0)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_msb),
    .in_ready  (in_ready_msb),
    .in_vec    (in_vec),
    .out_valid (out_valid_msb),
    .out_ready (out_ready),
    .out_code  (out_code_msb),
    .out_last  (out_last_msb),
    .zero_seen (zero_seen_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference order: ascending index for LSB-first, descending for MSB-first.
  task automatic push_codes(input logic [7:0] vec);
    int n;
    int cnt;
    int idx;
    exp_t e;
    n   = $countones(vec);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      idx = sel_msb ? (7 - k) : k;
      if (vec[idx]) begin
        cnt++;
        e.code = 3'(idx);
        e.last = (cnt == n);
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] vec, input bit ordy);
    bit   exp_ready;
    exp_t e;
    logic o_ready, o_valid, o_last, o_zs;
    logic [2:0] o_code;
    in_valid_lsb = v & ~sel_msb;
    in_valid_msb = v & sel_msb;
    in_vec       = vec;
    out_ready    = ordy;
    #1;
    o_ready = sel_msb ? in_ready_msb  : in_ready_lsb;
    o_valid = sel_msb ? out_valid_msb : out_valid_lsb;
    o_code  = sel_msb ? out_code_msb  : out_code_lsb;
    o_last  = sel_msb ? out_last_msb  : out_last_lsb;
    o_zs    = sel_msb ? zero_seen_msb : zero_seen_lsb;
    exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("in_ready", {7'd0, o_ready}, {7'd0, exp_ready});
    chk("out_valid", {7'd0, o_valid}, {7'd0, q.size() != 0});
    chk("zero_seen", {7'd0, o_zs}, {7'd0, zs_exp});
    zs_exp = 1'b0;
    if (q.size() != 0) begin
      e = q[0];
      chk("out_code", {5'd0, o_code}, {5'd0, e.code});
      chk("out_last", {7'd0, o_last}, {7'd0, e.last});
      $display("t=%0t msb=%0d code=%0d last=%0d ready=%0d", $time, sel_msb, o_code, o_last, ordy);
      if (ordy) e = q.pop_front();
    end
    if (v && exp_ready) begin
      if (vec == 8'h00) zs_exp = 1'b1;
      else push_codes(vec);
      $display("t=%0t msb=%0d accept vec=%02h", $time, sel_msb, vec);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    while (q.size() != 0) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic reset_cycle();
    rst_n        = 1'b0;
    in_valid_lsb = 1'b0;
    in_valid_msb = 1'b0;
    out_ready    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    zs_exp = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid_lsb = 1'b0;
    in_valid_msb = 1'b0;
    in_vec       = 8'h00;
    out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {7'd0, out_valid_lsb}, 8'd0);
    chk("rst_out_code", {5'd0, out_code_lsb}, 8'd0);
    chk("rst_out_last", {7'd0, out_last_lsb}, 8'd0);
    chk("rst_zero_seen", {7'd0, zero_seen_lsb}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready_lsb}, 8'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // LSB-first basic stream: 2,5,7
    sel_msb = 1'b0;
    step(1'b1, 8'b1010_0100, 1'b1);
    drain();

    // MSB-first: 7,5,2
    sel_msb = 1'b1;
    step(1'b1, 8'b1010_0100, 1'b1);
    drain();
    sel_msb = 1'b0;

    // Backpressure on first code
    step(1'b1, 8'b1010_0100, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    drain();

    // All-zero vector is dropped with a one-cycle pulse
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Back-to-back: A=81 then B=10 on A's final handshake
    step(1'b1, 8'h81, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h10, 1'b1);
    drain();

    // Full vector
    step(1'b1, 8'hFF, 1'b1);
    drain();

    // Reset mid-emission, then a single-bit vector
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    reset_cycle();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h08, 1'b1);
    drain();

    // MSB-first back-to-back with a zero vector at the final handshake
    sel_msb = 1'b1;
    step(1'b1, 8'h81, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
